// File: rtl/mem_wb_stage.sv
// Memory and writeback back-end: X/M register driving the dmem port, M/W register
// driving the regfile write port, plus M-stage bypass information for hazard handling.
module mem_wb_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [4:0]  op_x,
  input  logic [4:0]  alu_op_x,
  input  logic [4:0]  rd_addr_x,
  input  logic [31:0] alu_out_x,
  input  logic        alu_ovf_x,
  input  logic [31:0] regB_x,
  input  logic [31:0] pc_x,
  input  logic [31:0] tgt_x,
  output logic [11:0] dmem_address,
  output logic [31:0] dmem_data_in,
  output logic        dmem_wren,
  input  logic [31:0] dmem_q,
  output logic        regfile_write_enable,
  output logic [4:0]  regfile_write_addr,
  output logic [31:0] rd_writedata,
  output logic        bypass_m_we,
  output logic [4:0]  bypass_m_addr,
  output logic [31:0] bypass_m_data,
  output logic        bypass_m_is_lw
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;

  logic [31:0] xm_value_q, xm_value_d;
  logic [4:0]  xm_dest_q, xm_dest_d;
  logic        xm_we_q, xm_we_d;
  logic        xm_is_lw_q, xm_is_lw_d;
  logic        xm_is_sw_q, xm_is_sw_d;
  logic [31:0] xm_store_q, xm_store_d;
  logic        we_raw;

  logic [31:0] mw_value_q;
  logic [4:0]  mw_dest_q;
  logic        mw_we_q;
  logic        mw_is_lw_q;

  // Decode X-stage inputs into the X/M fields, including overflow/jal/setx rewriting.
  always_comb begin
    xm_value_d = 32'd0;
    xm_dest_d  = 5'd0;
    we_raw     = 1'b0;
    xm_is_lw_d = 1'b0;
    xm_is_sw_d = 1'b0;
    xm_store_d = 32'd0;
    case (op_x)
      OP_R: begin
        we_raw = 1'b1;
        if (alu_ovf_x && (alu_op_x == ALU_ADD)) begin
          xm_value_d = 32'd1;
          xm_dest_d  = REG_RSTATUS;
        end else if (alu_ovf_x && (alu_op_x == ALU_SUB)) begin
          xm_value_d = 32'd3;
          xm_dest_d  = REG_RSTATUS;
        end else begin
          xm_value_d = alu_out_x;
          xm_dest_d  = rd_addr_x;
        end
      end
      OP_ADDI: begin
        we_raw = 1'b1;
        if (alu_ovf_x) begin
          xm_value_d = 32'd2;
          xm_dest_d  = REG_RSTATUS;
        end else begin
          xm_value_d = alu_out_x;
          xm_dest_d  = rd_addr_x;
        end
      end
      OP_LW: begin
        we_raw     = 1'b1;
        xm_value_d = alu_out_x;
        xm_dest_d  = rd_addr_x;
        xm_is_lw_d = 1'b1;
      end
      OP_JAL: begin
        we_raw     = 1'b1;
        xm_value_d = pc_x;
        xm_dest_d  = REG_RA;
      end
      OP_SETX: begin
        we_raw     = 1'b1;
        xm_value_d = tgt_x;
        xm_dest_d  = REG_RSTATUS;
      end
      OP_SW: begin
        xm_value_d = alu_out_x;
        xm_is_sw_d = 1'b1;
        xm_store_d = regB_x;
      end
      default: begin
        we_raw = 1'b0;
      end
    endcase
    // r0 is hardwired; never request a write to it.
    xm_we_d = we_raw & (xm_dest_d != 5'd0);
  end

  // X/M register: holds on stall, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      xm_value_q <= 32'd0;
      xm_dest_q  <= 5'd0;
      xm_we_q    <= 1'b0;
      xm_is_lw_q <= 1'b0;
      xm_is_sw_q <= 1'b0;
      xm_store_q <= 32'd0;
    end else if (!stall) begin
      xm_value_q <= xm_value_d;
      xm_dest_q  <= xm_dest_d;
      xm_we_q    <= xm_we_d;
      xm_is_lw_q <= xm_is_lw_d;
      xm_is_sw_q <= xm_is_sw_d;
      xm_store_q <= xm_store_d;
    end else begin
      xm_value_q <= xm_value_q;
      xm_dest_q  <= xm_dest_q;
      xm_we_q    <= xm_we_q;
      xm_is_lw_q <= xm_is_lw_q;
      xm_is_sw_q <= xm_is_sw_q;
      xm_store_q <= xm_store_q;
    end
  end

  // M/W register: takes a bubble on stall so the held M instruction commits only once.
  always_ff @(posedge clock) begin
    if (reset || stall) begin
      mw_value_q <= 32'd0;
      mw_dest_q  <= 5'd0;
      mw_we_q    <= 1'b0;
      mw_is_lw_q <= 1'b0;
    end else begin
      mw_value_q <= xm_value_q;
      mw_dest_q  <= xm_dest_q;
      mw_we_q    <= xm_we_q;
      mw_is_lw_q <= xm_is_lw_q;
    end
  end

  assign dmem_address         = xm_value_q[11:0];
  assign dmem_data_in         = xm_store_q;
  assign dmem_wren            = xm_is_sw_q & ~stall;
  assign regfile_write_enable = mw_we_q;
  assign regfile_write_addr   = mw_dest_q;
  assign rd_writedata         = mw_is_lw_q ? dmem_q : mw_value_q;
  assign bypass_m_we          = xm_we_q;
  assign bypass_m_addr        = xm_dest_q;
  assign bypass_m_data        = xm_value_q;
  assign bypass_m_is_lw       = xm_is_lw_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory and writeback back-end of the five-stage pipeline. It consumes the execute-stage results (opcode, ALU result, overflow, store data, PC+1, jump target, destination), latches them in an X/M register and drives the dmem port. It then latches the M-stage outcome in an M/W register and drives the regfile write port. It also resolves jal/setx/overflow destination rewriting and exposes M-stage bypass information for the hazard unit.

## Interface
Parameters: none. Fixed widths: data 32, register address 5, dmem address 12.

- clock  in  1  pipeline clock; all registers update on rising edge
- reset  in  1  synchronous, active-high; clears X/M and M/W to bubbles
- stall  in  1  hold X/M, inject bubble into M/W, suppress dmem write
- op_x  in  5  X-stage opcode
- alu_op_x  in  5  X-stage ALU opcode (R-type only)
- rd_addr_x  in  5  X-stage destination field
- alu_out_x  in  32  ALU1 result
- alu_ovf_x  in  1  ALU1 overflow
- regB_x  in  32  store data (rd value for sw)
- pc_x  in  32  PC+1 of X instruction
- tgt_x  in  32  zero-extended 27-bit target
- dmem_address  out  12  dmem address = X/M value[11:0]
- dmem_data_in  out  32  X/M store data
- dmem_wren  out  1  X/M is sw and not stall
- dmem_q  in  32  dmem read data, registered in dmem, valid after edge that loads M/W
- regfile_write_enable  out  1  W-stage write enable (never for r0)
- regfile_write_addr  out  5  W-stage destination
- rd_writedata  out  32  W-stage write data
- bypass_m_we, bypass_m_addr[4:0], bypass_m_data[31:0], bypass_m_is_lw  out  M-stage forwarding info

## Operation
Opcodes: R 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110. ALU ops: add 00000, sub 00001.

The X/M load computes the following fields from the X inputs:
- value/dest/we:
  - R-type add with ovf: value 1, dest 30, we 1
  - R-type sub with ovf: value 3, dest 30, we 1
  - addi with ovf: value 2, dest 30, we 1
  - other R-type: value alu_out_x, dest rd, we 1
  - addi: alu_out_x, rd, 1
  - lw: alu_out_x, rd, 1, is_lw 1
  - jal: pc_x, 31, 1
  - setx: tgt_x, 30, 1
  - sw: alu_out_x, dest 0, we 0, is_sw 1, store data regB_x
  - j/bne/blt/jr/bex/unknown opcodes: we 0
- Overflow is ignored for non-add/sub/addi operations.
- If the final dest is 0, we is forced to 0.

The M/W load latches value, dest, we and is_lw from X/M.

W stage outputs:
- rd_writedata = is_lw ? dmem_q : value
- regfile_write_enable = we
- regfile_write_addr = dest

M-stage bypass outputs:
- bypass_m_* mirror X/M dest, we, value and is_lw.
- The hazard unit must stall on a load-use when bypass_m_is_lw=1, because the value is not the loaded data.

Stall:
- At an edge with stall=1, X/M holds and M/W loads a bubble (all zero).
- dmem_wren is 0 while stall=1. The store executes in the first non-stall cycle.

Reset:
- Reset dominates stall.
- Both registers clear to zero, so every output is 0: dmem_address 0, dmem_data_in 0, dmem_wren 0, regfile_write_enable 0, addr 0, data 0, bypass outputs 0.
- Reset mid-operation discards in-flight instructions; no write occurs in the cycle after the reset edge.

## Timing
Edge numbering:
- E1: X inputs sampled into X/M.
- Cycle after E1 (M): dmem signals are driven.
- E2: dmem write, dmem read address registered, M/W loaded.
- Cycle after E2 (W): regfile write signals are driven; the regfile commits at E3.

Rules:
- X-to-regfile-write latency is 2 cycles. This is unchanged for lw; dmem_q is valid throughout W.
- Throughput is one instruction per cycle when stall=0.
- Back-to-back sw then lw to the same address: the lw reads the new data (write at E2, read address at E3).
- Outputs are combinational only from register state and stall (dmem_wren). They never depend combinationally on X inputs.

## Test plan
- Reset held 2 cycles with X driving addi: all outputs 0. The first write appears 2 cycles after reset deasserts and addi is presented.
- add r3=r1+r2 with alu_out_x=0x00000007: W cycle shows we=1, addr 3, data 7. Same with alu_ovf_x=1: addr 30, data 1. sub overflow gives data 3; addi overflow gives data 2.
- sw with alu_out_x=0x00000010, regB_x=0xDEADBEEF, then lw rd=5 same address: dmem_wren=1 for one cycle with address 0x010. The lw W cycle writes r5=0xDEADBEEF.
- jal with pc_x=0x00000042: r31 ← 0x42. setx with tgt_x=0x0000ABCD: r30 ← 0xABCD. bne/j/jr/bex: regfile_write_enable stays 0.
- R-type with rd=0 and alu_out_x=5: regfile_write_enable=0.
- sw in M with stall high for 3 cycles: dmem_wren=0 and W shows bubbles during stall. Store pulses once in the release cycle; the following instruction writes back exactly once.
